// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic valid/ready buffer between two adjacent pipeline
// stages. Holds up to DEPTH payloads in FIFO order, reports occupancy and
// supports a single-cycle synchronous flush.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       asynchronous active-low reset
//   flush      discard all buffered entries on the next edge
//   in_valid   upstream payload valid
//   in_ready   buffer can accept this cycle (state only, no path from out_ready)
//   in_data    upstream payload
//   out_valid  head entry valid
//   out_ready  downstream consumes the head entry this cycle
//   out_data   head entry payload
//   count      number of valid entries, 0..DEPTH
module pipe_stage_buf #(
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  DEPTH  = 2,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     count
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              push;
    logic              pop;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Handshake status comes from registered occupancy only.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Flush blocks both transfers so a flushed push never lands in storage.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Next-state: storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset clears storage so out_data reads zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf: DEPTH=2 (vector table, streaming, reset),
// DEPTH=3 (random traffic against a queue model), DEPTH=1 (alternation).
module tb_pipe_stage_buf;

    localparam int unsigned W = 8;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;

    // DEPTH = 2 instance
    logic         a_flush, a_iv, a_ir, a_ov, a_or;
    logic [W-1:0] a_din, a_dout;
    logic [1:0]   a_cnt;
    // DEPTH = 3 instance
    logic         b_flush, b_iv, b_ir, b_ov, b_or;
    logic [W-1:0] b_din, b_dout;
    logic [1:0]   b_cnt;
    // DEPTH = 1 instance
    logic         c_flush, c_iv, c_ir, c_ov, c_or;
    logic [W-1:0] c_din, c_dout;
    logic [0:0]   c_cnt;

    pipe_stage_buf #(.DATA_W(W), .DEPTH(2)) u_d2 (
        .CLK(CLK), .nRST(nRST), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_din), .out_valid(a_ov), .out_ready(a_or), .out_data(a_dout), .count(a_cnt));
    pipe_stage_buf #(.DATA_W(W), .DEPTH(3)) u_d3 (
        .CLK(CLK), .nRST(nRST), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_din), .out_valid(b_ov), .out_ready(b_or), .out_data(b_dout), .count(b_cnt));
    pipe_stage_buf #(.DATA_W(W), .DEPTH(1)) u_d1 (
        .CLK(CLK), .nRST(nRST), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_din), .out_valid(c_ov), .out_ready(c_or), .out_data(c_dout), .count(c_cnt));

    typedef struct packed {
        logic         flush;
        logic         iv;
        logic [W-1:0] din;
        logic         ordy;
        logic [1:0]   cnt;
        logic         ir;
        logic         ov;
        logic [W-1:0] dout;
        logic         cd;      // compare out_data only when it is meaningful
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [W-1:0] q3 [$];
    logic         acc, pp, stalled;

    initial begin
        // inputs: flush, in_valid, in_data, out_ready | expected after edge
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 2'd1, 1'b1, 1'b1, 8'h11, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 2'd2, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 2'd2, 1'b0, 1'b1, 8'h11, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 1'b1, 8'h22, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 2'd1, 1'b1, 1'b1, 8'h33, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 2'd1, 1'b1, 1'b1, 8'h55, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h66, 1'b0, 2'd2, 1'b0, 1'b1, 8'h55, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 8'h44, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'h77, 1'b0, 2'd1, 1'b1, 1'b1, 8'h77, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 8'h44, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'h88, 1'b1, 2'd1, 1'b1, 1'b1, 8'h88, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 1'b0, 8'h00, 1'b0};

        {a_flush, a_iv, a_or, a_din} = '0;
        {b_flush, b_iv, b_or, b_din} = '0;
        {c_flush, c_iv, c_or, c_din} = '0;
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #6;
        chk("rst_count", a_cnt, 0);
        chk("rst_out_valid", a_ov, 0);
        chk("rst_in_ready", a_ir, 1);
        chk("rst_out_data", a_dout, 0);
        #5 nRST = 1'b1;

        // Vector table on DEPTH=2: backpressure and flush collisions
        for (int i = 0; i < 14; i++) begin
            a_flush = vecs[i].flush;
            a_iv    = vecs[i].iv;
            a_din   = vecs[i].din;
            a_or    = vecs[i].ordy;
            step();
            chk($sformatf("vec%0d_count", i), a_cnt, vecs[i].cnt);
            chk($sformatf("vec%0d_in_ready", i), a_ir, vecs[i].ir);
            chk($sformatf("vec%0d_out_valid", i), a_ov, vecs[i].ov);
            if (vecs[i].cd) chk($sformatf("vec%0d_out_data", i), a_dout, vecs[i].dout);
        end
        a_flush = 1'b0;

        // Streaming on DEPTH=2: one transfer per cycle, count steady at 1
        for (int i = 1; i <= 8; i++) begin
            a_iv = 1'b1; a_din = W'(i); a_or = 1'b1;
            chk($sformatf("stream%0d_in_ready", i), a_ir, 1);
            step();
            chk($sformatf("stream%0d_out_data", i), a_dout, i);
            chk($sformatf("stream%0d_count", i), a_cnt, 1);
        end
        a_iv = 1'b0;
        step();
        chk("stream_drain_count", a_cnt, 0);

        // Asynchronous reset mid-cycle with two entries buffered
        a_or = 1'b0; a_iv = 1'b1; a_din = 8'h12;
        step();
        a_din = 8'h34;
        step();
        chk("midrst_pre_count", a_cnt, 2);
        a_iv = 1'b0;
        #3 nRST = 1'b0;
        #1;
        chk("midrst_count", a_cnt, 0);
        chk("midrst_out_valid", a_ov, 0);
        chk("midrst_in_ready", a_ir, 1);
        chk("midrst_out_data", a_dout, 0);
        #1 nRST = 1'b1;
        a_iv = 1'b1; a_din = 8'hA5;
        step();
        chk("postrst_out_valid", a_ov, 1);
        chk("postrst_out_data", a_dout, 8'hA5);
        a_iv = 1'b0; a_or = 1'b1;
        step();
        chk("postrst_drain_count", a_cnt, 0);
        a_or = 1'b0;

        // Random traffic on DEPTH=3 against a FIFO queue model
        stalled = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!stalled) begin
                b_iv  = 1'($urandom_range(0, 1));
                b_din = W'($urandom);
            end
            b_or    = 1'($urandom_range(0, 1));
            b_flush = ($urandom_range(0, 24) == 0);
            chk("d3_in_ready", b_ir, q3.size() < 3);
            chk("d3_out_valid", b_ov, q3.size() != 0);
            if (q3.size() != 0) chk("d3_out_data", b_dout, q3[0]);
            acc = b_iv && (q3.size() < 3);
            pp  = b_or && (q3.size() > 0);
            step();
            if (b_flush) begin
                q3.delete();
                stalled = 1'b0;
            end else begin
                if (pp) void'(q3.pop_front());
                if (acc) q3.push_back(b_din);
                stalled = b_iv && !acc;
            end
            chk("d3_count", b_cnt, q3.size());
        end
        {b_flush, b_iv, b_or} = '0;

        // DEPTH=1 continuous flow: in_ready alternates, one transfer per 2 cycles
        c_iv = 1'b1; c_or = 1'b1;
        for (int k = 0; k < 12; k++) begin
            c_din = W'(k / 2 + 1);
            chk($sformatf("d1_k%0d_in_ready", k), c_ir, (k % 2) == 0);
            step();
            if ((k % 2) == 0) begin
                chk($sformatf("d1_k%0d_out_valid", k), c_ov, 1);
                chk($sformatf("d1_k%0d_out_data", k), c_dout, k / 2 + 1);
                chk($sformatf("d1_k%0d_count", k), c_cnt, 1);
            end else begin
                chk($sformatf("d1_k%0d_out_valid", k), c_ov, 0);
                chk($sformatf("d1_k%0d_count", k), c_cnt, 0);
            end
        end
        {c_iv, c_or} = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage buffer that carries an arbitrary stage payload (e.g. the packed execute-to-memory bundle) between two CPU pipeline stages. It replaces the plain enable/flush latch with a valid/ready handshake and a DEPTH-entry in-order buffer, so a stalled downstream stage no longer forces the upstream stage to stall in the same cycle. It also reports occupancy and supports a single-cycle flush. It sits between any two adjacent stages (fetch/decode, decode/execute, execute/memory, memory/writeback).

## Interface
- DATA_W, default 32: payload width in bits, minimum 1.
- DEPTH, default 2: number of buffered entries, minimum 1; need not be a power of two.
- CW, derived as $clog2(DEPTH+1): occupancy counter width.

- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush; discards all buffered entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  buffer can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  DATA_W  head entry payload.
- count  out  CW  number of valid entries, 0..DEPTH.

## Operation
- Storage is a circular array `mem[DEPTH]` with read pointer rd_ptr, write pointer wr_ptr and counter count.
- Control signals:
  - in_ready = (count != DEPTH). It is registered-state-only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr].
- push = in_valid & in_ready. On push, mem[wr_ptr] ← in_data and wr_ptr advances.
- pop = out_valid & out_ready. On pop, rd_ptr advances.
- Pointer advance: ptr == DEPTH-1 wraps to 0; otherwise ptr+1.
- count update: push only +1; pop only −1; push and pop together: unchanged.
- Full with pop in the same cycle: in_ready is already 0, so there is no push that cycle and count drops by 1.
- Empty: out_valid is 0. in_data is never forwarded combinationally, so the minimum latency is 1 cycle.
- flush has highest priority. On the next edge count, rd_ptr and wr_ptr all go to 0. A push or pop in the flush cycle has no effect, and a flushed entry never appears on out_data. mem contents are left unchanged.
- Upstream must hold in_data/in_valid stable while in_valid & !in_ready. The buffer does not check this.
- out_data is don't-care while out_valid = 0.
- Throughput:
  - DEPTH = 1 sustains at most one transfer per 2 cycles under continuous flow, because there is no push while full.
  - DEPTH ≥ 2 sustains one transfer per cycle.
- Order is strict FIFO. Entries are never dropped or duplicated except by flush or reset.

## Timing
- Reset (nRST low, asynchronous, takes effect immediately without a clock edge):
  - count = 0, rd_ptr = 0, wr_ptr = 0, all mem entries = 0.
  - Therefore out_valid = 0, in_ready = 1, out_data = 0.
- Reset mid-operation discards all entries. The first edge after nRST rises may accept a push.
- Push at edge N gives out_valid = 1 after edge N if the buffer was empty.
- count, in_ready and out_valid change only on CLK edges or reset.
- flush asserted for the cycle ending at edge N gives count = 0, out_valid = 0, in_ready = 1 after edge N.

## Test plan
- Reset: hold nRST low mid-cycle with count = 2 → out_valid = 0, in_ready = 1, count = 0 immediately, before any edge; after release, push 0xA5 → out_data = 0xA5 one cycle later.
- Streaming, DEPTH = 2: in_valid = 1 with data 1..8 on consecutive cycles, out_ready = 1 → outputs 1..8 on consecutive cycles starting 1 cycle after the first push; count = 1 steady; in_ready always 1.
- Backpressure, DEPTH = 2: out_ready = 0, offer 0x11, 0x22, 0x33 → 0x11 and 0x22 accepted, count = 2, in_ready = 0, and 0x33 held upstream; raise out_ready → order 0x11, 0x22, 0x33 with no loss.
- Flush collision: count = 2, and in the same cycle flush = 1, push 0x44, pop → next cycle count = 0, out_valid = 0; 0x44 never observed on out_data.
- Wrap, DEPTH = 3: push/pop 10 values with random in_valid/out_ready → output sequence equals input sequence; count never exceeds 3; pointers wrap 2→0.
- DEPTH = 1: continuous in_valid, out_ready = 1 → in_ready alternates 1/0, with one transfer every 2 cycles.
